dump_pulse_gen: RTL and testbench
=================================

# dump_pulse_gen

Multi-channel, programmable successor to the single-output dump generator. On each rising edge of the pulse-sequencer `state_start` it produces, per enabled channel, a Q-damping `dump_on` pulse with independently programmable delay and width in `clk_sys` cycles. It sits between the sequencer state machine and the per-coil dump switch drivers, and is configured through a simple register-write port driven by the DSP interface.

## Interface
Parameters:
- `N_CH`, 2: number of dump channels (1..64).
- `CNT_W`, 16: width of the delay and width counters and registers.
- `DEF_DELAY`, 16'd10: reset value of every channel's delay register.
- `DEF_WIDTH`, 16'd50: reset value of every channel's width register.

Ports:
- `clk_sys`  in  1  system clock; the single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `state_start`  in  1  trigger level from the sequencer, synchronous to `clk_sys`; its rising edge starts a pulse.
- `ch_en`  in  N_CH  per-channel enable, sampled at the trigger cycle.
- `abort`  in  1  synchronous kill of all channels.
- `cfg_we`  in  1  register write strobe.
- `cfg_addr`  in  8  bit0 selects the register (0 = delay, 1 = width); bits[7:1] select the channel.
- `cfg_data`  in  CNT_W  write data.
- `dump_on`  out  N_CH  registered dump pulses.
- `busy`  out  1  OR of all channels not IDLE.
- `retrig_err`  out  1  one-cycle flag: a trigger arrived while an enabled channel was active.

## Operation
- Edge detect: `start_d` registers `state_start`. A trigger is `state_start & ~start_d`. Reset value of `start_d` is 0, so a level already high at reset release triggers once.
- Per-channel FSM with states IDLE, DELAY and ON, plus a CNT_W counter and working copies of delay D and width W.
- IDLE: on a trigger with `ch_en[i]`=1 and no abort, latch D and W from the registers.
  - W=0: stay in IDLE; no pulse.
  - D=0 and W>0: go to ON.
  - D>0 and W>0: go to DELAY.
- DELAY: count D cycles, then go to ON.
- ON: `dump_on[i]`=1 for exactly W cycles, then return to IDLE.
- Retrigger: a trigger arriving while channel i is in DELAY or ON is ignored by that channel; the pulse in progress is unaffected. If `ch_en[i]`=1, `retrig_err`=1 for one cycle. Idle enabled channels still start on that trigger.
- Abort: every channel goes to IDLE and `dump_on` is all-zero on the next edge.
  - Abort in the same cycle as a trigger: abort wins and no channel starts.
  - Abort has priority over config writes only in FSM terms; writes still land.
- Config:
  - Writes with channel index >= N_CH are ignored.
  - A write in the same cycle as a trigger is applied to the register, but the trigger latches the old value.
  - Writes during DELAY or ON never alter the running pulse.
  - There is no read path.
- Reset values:
  - `dump_on`=0, `busy`=0, `retrig_err`=0.
  - All FSMs are in IDLE, all counters are 0.
  - Delay registers = DEF_DELAY, width registers = DEF_WIDTH.

## Timing
- Trigger recognised at edge T0, where `state_start` is sampled high and `start_d` is 0.
- `dump_on[i]` rises at edge T0+1+D and falls at edge T0+1+D+W, giving a high time of exactly W cycles.
- `busy` rises at T0+1 if any channel started, and falls at the edge where the last channel returns to IDLE, which is the same edge its `dump_on` falls.
- `retrig_err` is high for the single cycle following the offending trigger edge.
- Maximum D and W are 2^CNT_W−1. There is no wrap: the counters stop at the terminal count.
- Asserting `rst_n` low mid-pulse clears `dump_on` asynchronously and immediately.
- Back-to-back pulses: the earliest next pulse requires `state_start` low for at least one sampled cycle after the channel has returned to IDLE.

## Test plan
- Defaults, N_CH=2, both enabled: `state_start` rises at T0 -> both `dump_on` high from T0+11 to T0+61 (50 cycles); `busy` high from T0+1 to T0+61.
- Write ch1 delay=0 and width=3, and ch0 width=0, then trigger -> ch0 stays low and `retrig_err`=0; ch1 is high at T0+1..T0+3 (3 cycles).
- Retrigger: pulse the trigger again during ch0's DELAY -> `retrig_err` is a single-cycle pulse and the ch0 pulse timing is unchanged from the first trigger.
- Abort at T0+20 during ON (D=5, W=100) -> `dump_on`=0 and `busy`=0 from T0+21. Abort coincident with a trigger -> no pulse at all.
- Write ch0 width=7 in the same cycle as a trigger -> that pulse is 50 cycles wide and the next trigger gives 7. A write to channel index 5 changes nothing.
- `rst_n` low at mid-pulse -> `dump_on` drops without waiting for a clock. After release, the registers read back DEF values, verified by a trigger producing a D=10, W=50 pulse.

Source files
------------

// File: rtl/dump_pulse_gen.sv
// Multi-channel Q-damping dump pulse generator: each enabled channel emits one
// programmable delay/width pulse per rising edge of the sequencer start level.
module dump_pulse_gen #(
    parameter int               N_CH      = 2,
    parameter int               CNT_W     = 16,
    parameter logic [CNT_W-1:0] DEF_DELAY = CNT_W'(10),
    parameter logic [CNT_W-1:0] DEF_WIDTH = CNT_W'(50)
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             state_start,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             abort,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    output logic [N_CH-1:0]  dump_on,
    output logic             busy,
    output logic             retrig_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t           r_state     [N_CH];
    logic [CNT_W-1:0] r_cnt       [N_CH];
    logic [CNT_W-1:0] r_wid_lat   [N_CH];
    logic [CNT_W-1:0] r_delay_reg [N_CH];
    logic [CNT_W-1:0] r_width_reg [N_CH];

    logic            r_start_d;
    logic            r_busy;
    logic            r_retrig;
    logic [N_CH-1:0] r_dump_on;

    logic            w_trig;
    logic [N_CH-1:0] w_active;
    logic [6:0]      w_cfg_ch;
    logic            w_cfg_sel_w;

    assign w_trig      = state_start & ~r_start_d;
    assign w_cfg_ch    = cfg_addr[7:1];
    assign w_cfg_sel_w = cfg_addr[0];

    always_comb begin
        w_active = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_active[i] = (r_state[i] != S_IDLE);
        end
    end

    // Channel indices beyond N_CH simply match no register and are dropped.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_delay_reg[i] <= DEF_DELAY;
                r_width_reg[i] <= DEF_WIDTH;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_cfg_ch == 7'(i)) begin
                    if (w_cfg_sel_w) begin
                        r_width_reg[i] <= cfg_data;
                    end else begin
                        r_delay_reg[i] <= cfg_data;
                    end
                end
            end
        end
    end

    // Outputs lag the FSM state by one edge, so dump_on rises at T0+1+D and
    // busy falls on the same edge as the last dump_on.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d <= 1'b0;
            r_busy    <= 1'b0;
            r_retrig  <= 1'b0;
            r_dump_on <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i]   <= S_IDLE;
                r_cnt[i]     <= '0;
                r_wid_lat[i] <= '0;
            end
        end else begin
            r_start_d <= state_start;
            r_retrig  <= w_trig & (|(ch_en & w_active));
            r_busy    <= ~abort & (|w_active);
            for (int i = 0; i < N_CH; i++) begin
                if (abort) begin
                    r_state[i]   <= S_IDLE;
                    r_cnt[i]     <= '0;
                    r_dump_on[i] <= 1'b0;
                end else begin
                    r_dump_on[i] <= (r_state[i] == S_ON);
                    case (r_state[i])
                        S_IDLE: begin
                            if (w_trig && ch_en[i] && (r_width_reg[i] != '0)) begin
                                r_wid_lat[i] <= r_width_reg[i];
                                if (r_delay_reg[i] == '0) begin
                                    r_state[i] <= S_ON;
                                    r_cnt[i]   <= r_width_reg[i];
                                end else begin
                                    r_state[i] <= S_DELAY;
                                    r_cnt[i]   <= r_delay_reg[i];
                                end
                            end
                        end
                        S_DELAY: begin
                            if (r_cnt[i] <= CNT_W'(1)) begin
                                r_state[i] <= S_ON;
                                r_cnt[i]   <= r_wid_lat[i];
                            end else begin
                                r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                            end
                        end
                        S_ON: begin
                            if (r_cnt[i] <= CNT_W'(1)) begin
                                r_state[i] <= S_IDLE;
                                r_cnt[i]   <= '0;
                            end else begin
                                r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                            end
                        end
                        default: begin
                            r_state[i] <= S_IDLE;
                            r_cnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign dump_on    = r_dump_on;
    assign busy       = r_busy;
    assign retrig_err = r_retrig;

endmodule

// File: tb/tb_dump_pulse_gen.sv
// Directed self-checking bench for dump_pulse_gen (N_CH=2, CNT_W=16 defaults).
`timescale 1ns/1ps
module tb_dump_pulse_gen;

    logic        clk_sys;
    logic        rst_n;
    logic        state_start;
    logic [1:0]  ch_en;
    logic        abort;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [1:0]  dump_on;
    logic        busy;
    logic        retrig_err;

    int checks;
    int passes;

    dump_pulse_gen #(
        .N_CH      (2),
        .CNT_W     (16),
        .DEF_DELAY (16'd10),
        .DEF_WIDTH (16'd50)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .state_start (state_start),
        .ch_en       (ch_en),
        .abort       (abort),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .dump_on     (dump_on),
        .busy        (busy),
        .retrig_err  (retrig_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Advance one clock and land 1ns after the edge, where outputs are stable.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Leaves the bench just after T0 (the edge that samples the rising start).
    task automatic trigger();
        state_start = 1'b1;
        tick();
        state_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        state_start = 1'b0;
        ch_en       = 2'b00;
        abort       = 1'b0;
        cfg_we      = 1'b0;
        cfg_addr    = 8'd0;
        cfg_data    = 16'd0;
        #3;
        checks++;
        if (dump_on !== 2'b00) $display("[TB] FAIL reset_dump_on got=%b exp=00", dump_on);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy);
        else passes++;
        checks++;
        if (retrig_err !== 1'b0) $display("[TB] FAIL reset_retrig got=%b exp=0", retrig_err);
        else passes++;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({dump_on, busy, retrig_err} !== 4'b0000)
                $display("[TB] FAIL post_reset_idle k=%0d got=%b exp=0000", k, {dump_on, busy, retrig_err});
            else passes++;
        end
    endtask

    task automatic test_defaults();
        logic [3:0] exp;
        ch_en = 2'b11;
        trigger();
        checks++;
        if ({dump_on, busy, retrig_err} !== 4'b0000)
            $display("[TB] FAIL defaults_t0 got=%b exp=0000", {dump_on, busy, retrig_err});
        else passes++;
        for (int k = 1; k <= 65; k++) begin
            tick();
            exp = {((k >= 11 && k <= 60) ? 2'b11 : 2'b00), (k <= 60), 1'b0};
            checks++;
            if ({dump_on, busy, retrig_err} !== exp)
                $display("[TB] FAIL defaults k=%0d got=%b exp=%b", k, {dump_on, busy, retrig_err}, exp);
            else passes++;
        end
    endtask

    task automatic test_zero_delay_width();
        logic [3:0] exp;
        cfg_write(8'd2, 16'd0);
        cfg_write(8'd3, 16'd3);
        cfg_write(8'd1, 16'd0);
        ch_en = 2'b11;
        trigger();
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp = {(k <= 3), 1'b0, (k <= 3), 1'b0};
            checks++;
            if ({dump_on, busy, retrig_err} !== exp)
                $display("[TB] FAIL zero_dw k=%0d got=%b exp=%b", k, {dump_on, busy, retrig_err}, exp);
            else passes++;
        end
    endtask

    task automatic test_retrigger();
        logic [3:0] exp;
        cfg_write(8'd0, 16'd8);
        cfg_write(8'd1, 16'd5);
        ch_en = 2'b01;
        trigger();
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp = {1'b0, (k >= 9 && k <= 13), (k <= 13), (k == 3)};
            checks++;
            if ({dump_on, busy, retrig_err} !== exp)
                $display("[TB] FAIL retrigger k=%0d got=%b exp=%b", k, {dump_on, busy, retrig_err}, exp);
            else passes++;
            if (k == 2) state_start = 1'b1;
            if (k == 3) state_start = 1'b0;
        end
    endtask

    task automatic test_abort();
        logic [3:0] exp;
        cfg_write(8'd0, 16'd5);
        cfg_write(8'd1, 16'd100);
        cfg_write(8'd2, 16'd5);
        cfg_write(8'd3, 16'd100);
        ch_en = 2'b11;
        trigger();
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp = {((k >= 6 && k <= 20) ? 2'b11 : 2'b00), (k <= 20), 1'b0};
            checks++;
            if ({dump_on, busy, retrig_err} !== exp)
                $display("[TB] FAIL abort_on k=%0d got=%b exp=%b", k, {dump_on, busy, retrig_err}, exp);
            else passes++;
            if (k == 20) abort = 1'b1;
            if (k == 21) abort = 1'b0;
        end
        abort       = 1'b1;
        state_start = 1'b1;
        tick();
        abort       = 1'b0;
        state_start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if ({dump_on, busy, retrig_err} !== 4'b0000)
                $display("[TB] FAIL abort_with_trig k=%0d got=%b exp=0000", k, {dump_on, busy, retrig_err});
            else passes++;
        end
    endtask

    task automatic test_cfg_race();
        logic [3:0] exp;
        cfg_write(8'd0, 16'd10);
        cfg_write(8'd1, 16'd50);
        ch_en       = 2'b01;
        cfg_we      = 1'b1;
        cfg_addr    = 8'd1;
        cfg_data    = 16'd7;
        state_start = 1'b1;
        tick();
        cfg_we      = 1'b0;
        state_start = 1'b0;
        for (int k = 1; k <= 63; k++) begin
            tick();
            exp = {1'b0, (k >= 11 && k <= 60), (k <= 60), 1'b0};
            checks++;
            if ({dump_on, busy, retrig_err} !== exp)
                $display("[TB] FAIL cfg_race_old k=%0d got=%b exp=%b", k, {dump_on, busy, retrig_err}, exp);
            else passes++;
        end
        trigger();
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = {1'b0, (k >= 11 && k <= 17), (k <= 17), 1'b0};
            checks++;
            if ({dump_on, busy, retrig_err} !== exp)
                $display("[TB] FAIL cfg_race_new k=%0d got=%b exp=%b", k, {dump_on, busy, retrig_err}, exp);
            else passes++;
        end
        cfg_write(8'd11, 16'd1);
        cfg_write(8'd10, 16'd1);
        trigger();
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = {1'b0, (k >= 11 && k <= 17), (k <= 17), 1'b0};
            checks++;
            if ({dump_on, busy, retrig_err} !== exp)
                $display("[TB] FAIL cfg_bad_ch k=%0d got=%b exp=%b", k, {dump_on, busy, retrig_err}, exp);
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp;
        cfg_write(8'd1, 16'd50);
        ch_en = 2'b11;
        trigger();
        for (int k = 1; k <= 20; k++) begin
            tick();
        end
        checks++;
        if (dump_on !== 2'b11) $display("[TB] FAIL pre_reset_pulse got=%b exp=11", dump_on);
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dump_on !== 2'b00) $display("[TB] FAIL async_reset_dump got=%b exp=00", dump_on);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL async_reset_busy got=%b exp=0", busy);
        else passes++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        trigger();
        for (int k = 1; k <= 65; k++) begin
            tick();
            exp = {((k >= 11 && k <= 60) ? 2'b11 : 2'b00), (k <= 60), 1'b0};
            checks++;
            if ({dump_on, busy, retrig_err} !== exp)
                $display("[TB] FAIL post_reset_defaults k=%0d got=%b exp=%b", k, {dump_on, busy, retrig_err}, exp);
            else passes++;
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_defaults();
        test_zero_delay_width();
        test_retrigger();
        test_abort();
        test_cfg_race();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
